// File: rtl/eth_fifo_pkg.sv
// Shared types for the Ethernet store-and-forward frame FIFO.
// Write-side FSM states and the pointer width helper.
package eth_fifo_pkg;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_FRAME,
        WR_DROP
    } wr_state_t;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/eth_fifo_ram.sv
// Simple dual-port RAM for the frame FIFO.
// Synchronous write port, asynchronous read port.
module eth_fifo_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store one beat per enabled write cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/eth_frame_fifo.sv
// Store-and-forward frame FIFO between MAC receive and host side.
// Frames become readable only once their last beat commits cleanly.
module eth_frame_fifo
    import eth_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              wr_err,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [ADDR_W:0]   frame_cnt,
    output logic [ADDR_W:0]   free_cnt,
    output logic              drop
);

    localparam int PTR_W = ptr_w(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t ONE_P   = ptr_t'(1);

    wr_state_t state_q, state_d;

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t cm_ptr_q, cm_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t frame_cnt_q, frame_cnt_d;
    logic drop_q, drop_d;

    ptr_t fill;
    logic full;
    logic we;
    logic commit;
    logic rd_fire;
    logic rd_done;

    logic [DATA_W:0] rd_word;

    // Occupancy counts unread committed beats plus the frame in flight.
    assign fill = wr_ptr_q - rd_ptr_q;
    assign full = (fill == DEPTH_P);

    // Write FSM: accept, commit or roll back the frame being received.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        drop_d   = 1'b0;
        we       = 1'b0;
        commit   = 1'b0;
        unique case (state_q)
            WR_IDLE, WR_FRAME: begin
                if (wr_valid) begin
                    if (full || wr_err) begin
                        wr_ptr_d = cm_ptr_q;
                        if (wr_last) begin
                            drop_d  = 1'b1;
                            state_d = WR_IDLE;
                        end else begin
                            state_d = WR_DROP;
                        end
                    end else if (wr_last) begin
                        we       = 1'b1;
                        commit   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_P;
                        cm_ptr_d = wr_ptr_q + ONE_P;
                        state_d  = WR_IDLE;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_P;
                        state_d  = WR_FRAME;
                    end
                end
            end
            WR_DROP: begin
                if (wr_valid && wr_last) begin
                    drop_d  = 1'b1;
                    state_d = WR_IDLE;
                end
            end
            default: begin
                state_d  = WR_IDLE;
                wr_ptr_d = cm_ptr_q;
            end
        endcase
    end

    // Read side: head beat is visible once any committed data remains.
    always_comb begin
        rd_valid = (frame_cnt_q != '0) || (rd_ptr_q != cm_ptr_q);
        rd_data  = rd_word[DATA_W-1:0];
        rd_last  = rd_word[DATA_W];
        rd_fire  = rd_valid && rd_ready;
        rd_done  = rd_fire && rd_word[DATA_W];
        rd_ptr_d = rd_fire ? rd_ptr_q + ONE_P : rd_ptr_q;
    end

    // Frame count: a commit and a frame-end read in one cycle cancel out.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        unique case ({commit, rd_done})
            2'b10:   frame_cnt_d = frame_cnt_q + ONE_P;
            2'b01:   frame_cnt_d = frame_cnt_q - ONE_P;
            default: frame_cnt_d = frame_cnt_q;
        endcase
    end

    // State and pointer registers; reset drops everything silently.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= WR_IDLE;
            wr_ptr_q    <= '0;
            cm_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cm_ptr_q    <= cm_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            drop_q      <= drop_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign free_cnt  = DEPTH_P - fill;
    assign drop      = drop_q;

    eth_fifo_ram #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i ({wr_last, wr_data}),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rd_word)
    );

endmodule

// File: tb/tb_eth_frame_fifo.sv
// Self-checking bench for eth_frame_fifo against a queue-based model.
// Directed scenarios plus randomized traffic at DEPTH=16.
module tb_eth_frame_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_last = 1'b0;
    logic          wr_err = 1'b0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic [AW:0]   frame_cnt;
    logic [AW:0]   free_cnt;
    logic          drop;

    int n_chk = 0;
    int n_err = 0;

    beat_t com[$];
    beat_t pend[$];
    beat_t rlog[$];
    bit    in_drop = 0;
    bit    drop_exp = 0;
    bit    chk_en = 0;
    int    drops_seen = 0;

    always #5 clk = ~clk;

    eth_frame_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .wr_err    (wr_err),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .frame_cnt (frame_cnt),
        .free_cnt  (free_cnt),
        .drop      (drop)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int model_frames();
        int n = 0;
        foreach (com[i]) if (com[i].last) n++;
        return n;
    endfunction

    // Reference model: committed beats, in-flight frame, drop flag.
    always @(posedge clk) begin
        bit fire;
        bit full;
        bit dn;
        if (!rst) begin
            com.delete();
            pend.delete();
            in_drop  = 0;
            drop_exp = 0;
        end else begin
            fire = (com.size() > 0) && rd_ready;
            full = (pend.size() + com.size()) == DEPTH;
            dn   = 0;
            if (wr_valid) begin
                if (in_drop) begin
                    if (wr_last) begin
                        dn      = 1;
                        in_drop = 0;
                    end
                end else if (full || wr_err) begin
                    pend.delete();
                    if (wr_last) dn = 1;
                    else in_drop = 1;
                end else begin
                    pend.push_back({wr_last, wr_data});
                    if (wr_last) begin
                        foreach (pend[i]) com.push_back(pend[i]);
                        pend.delete();
                    end
                end
            end
            if (fire) void'(com.pop_front());
            drop_exp = dn;
        end
    end

    // Compare DUT outputs with the model every cycle, log transfers.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_valid", 32'(rd_valid), 32'(com.size() > 0));
            if (com.size() > 0) begin
                chk("rd_data", 32'(rd_data), 32'(com[0].data));
                chk("rd_last", 32'(rd_last), 32'(com[0].last));
            end
            chk("frame_cnt", 32'(frame_cnt), 32'(model_frames()));
            chk("free_cnt", 32'(free_cnt),
                32'(DEPTH - pend.size() - com.size()));
            chk("drop", 32'(drop), 32'(drop_exp));
            if (rd_valid && rd_ready) rlog.push_back({rd_last, rd_data});
            if (drop) drops_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input bit last, input bit err);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        wr_err   = err;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_err   = 1'b0;
    endtask

    task automatic drain(input string nm);
        rd_ready = 1'b1;
        for (int i = 0; i < 80 && rd_valid; i++) tick();
        chk(nm, 32'(rd_valid), 32'(0));
    endtask

    task automatic chk_log(input string nm, input beat_t exp[$]);
        chk({nm, "_len"}, 32'(rlog.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < rlog.size()) chk(nm, 32'(rlog[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        beat_t exp[$];
        int    d0;

        tick();
        tick();
        chk_en = 1;
        chk("rst_rd_valid", 32'(rd_valid), 32'(0));
        chk("rst_free", 32'(free_cnt), 32'(16));
        chk("rst_frames", 32'(frame_cnt), 32'(0));
        chk("rst_drop", 32'(drop), 32'(0));
        rst = 1'b1;
        tick();

        // 5-byte frame, read as it becomes visible
        rlog.delete();
        rd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) wr(8'(i), 0, 0);
        chk("t1_hidden", 32'(rd_valid), 32'(0));
        wr(8'h05, 1, 0);
        chk("t1_visible", 32'(rd_valid), 32'(1));
        chk("t1_frames1", 32'(frame_cnt), 32'(1));
        drain("t1_drain");
        exp.delete();
        for (int i = 1; i <= 5; i++) exp.push_back({i == 5, 8'(i)});
        chk_log("t1_data", exp);
        chk("t1_frames0", 32'(frame_cnt), 32'(0));
        chk("t1_free", 32'(free_cnt), 32'(16));

        // errored frame is rolled back
        d0 = drops_seen;
        for (int i = 0; i < 3; i++) wr(8'h20 + 8'(i), 0, 0);
        wr(8'h23, 1, 1);
        chk("t2_drop_hi", 32'(drop), 32'(1));
        tick();
        chk("t2_drop_lo", 32'(drop), 32'(0));
        chk("t2_drops", 32'(drops_seen - d0), 32'(1));
        chk("t2_frames", 32'(frame_cnt), 32'(0));
        chk("t2_rd_valid", 32'(rd_valid), 32'(0));
        chk("t2_free", 32'(free_cnt), 32'(16));

        // overflow: B does not fit behind unread A
        rlog.delete();
        rd_ready = 1'b0;
        d0 = drops_seen;
        for (int i = 0; i < 10; i++) wr(8'hA0 + 8'(i), i == 9, 0);
        for (int i = 0; i < 8; i++) begin
            wr(8'hB0 + 8'(i), i == 7, 0);
            if (i == 5) chk("t3_full", 32'(free_cnt), 32'(0));
        end
        tick();
        chk("t3_drops", 32'(drops_seen - d0), 32'(1));
        chk("t3_frames", 32'(frame_cnt), 32'(1));
        chk("t3_free", 32'(free_cnt), 32'(6));
        drain("t3_drain");
        exp.delete();
        for (int i = 0; i < 10; i++) exp.push_back({i == 9, 8'hA0 + 8'(i)});
        chk_log("t3_data", exp);

        // commit C while D's last beat is read
        rlog.delete();
        rd_ready = 1'b0;
        wr(8'h31, 0, 0);
        wr(8'h32, 1, 0);
        rd_ready = 1'b1;
        tick();
        wr(8'hAA, 1, 0);
        chk("t4_frames", 32'(frame_cnt), 32'(1));
        chk("t4_data", 32'(rd_data), 32'(8'hAA));
        chk("t4_last", 32'(rd_last), 32'(1));
        drain("t4_drain");
        exp.delete();
        exp.push_back({1'b0, 8'h31});
        exp.push_back({1'b1, 8'h32});
        exp.push_back({1'b1, 8'hAA});
        chk_log("t4_log", exp);

        // reset mid-frame discards silently
        rlog.delete();
        rd_ready = 1'b0;
        d0 = drops_seen;
        for (int i = 0; i < 3; i++) wr(8'h51 + 8'(i), 0, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t5_rst_free", 32'(free_cnt), 32'(16));
        wr(8'h11, 0, 0);
        wr(8'h22, 1, 0);
        drain("t5_drain");
        exp.delete();
        exp.push_back({1'b0, 8'h11});
        exp.push_back({1'b1, 8'h22});
        chk_log("t5_log", exp);
        chk("t5_drops", 32'(drops_seen - d0), 32'(0));

        // 40 single-beat frames: pointers wrap
        rlog.delete();
        rd_ready = 1'b1;
        d0 = drops_seen;
        for (int i = 0; i < 40; i++) wr(8'(i * 3 + 7), 1, 0);
        drain("t6_drain");
        exp.delete();
        for (int i = 0; i < 40; i++) exp.push_back({1'b1, 8'(i * 3 + 7)});
        chk_log("t6_log", exp);
        chk("t6_drops", 32'(drops_seen - d0), 32'(0));
        chk("t6_free", 32'(free_cnt), 32'(16));

        // randomized traffic, alternating slow and fast readers
        for (int blk = 0; blk < 12; blk++) begin
            for (int c = 0; c < 150; c++) begin
                wr_valid = ($urandom % 4) != 0;
                wr_data  = 8'($urandom);
                wr_last  = ($urandom % 7) == 0;
                wr_err   = ($urandom % 50) == 0;
                rd_ready = blk[0] ? (($urandom % 4) != 0)
                                  : (($urandom % 5) == 0);
                tick();
            end
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_err   = 1'b0;
        wr(8'h77, 1, 0);
        wr(8'h78, 1, 0);
        drain("rand_drain");
        chk("rand_free", 32'(free_cnt), 32'(16));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
